// File: rtl/bp_pkg.sv
// Shared encodings for the bimodal branch predictor and its resolution controller.
package bp_pkg;
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_e;

  localparam logic [1:0] CTR_RESET = WNT;
endpackage

// File: rtl/bp_sat_ctr2.sv
// 2-bit saturating counter next-state: count up on taken, down on not-taken, hold at the ends.
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);
  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != SNT) o_ctr = i_ctr - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predict_ctrl.sv
// Bimodal predictor (2-bit BHT + tagged BTB) with EX-side mispredict detection,
// registered redirect/flush pulse and a recovery window that ignores wrong-path EX inputs.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W      = 6,
  parameter int XLEN       = 32,
  parameter int RECOVER_CY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] i_fetch_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_ex_valid,
  input  logic            i_ex_is_branch,
  input  logic            i_ex_taken,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_target,
  input  logic            i_ex_pred_taken,
  input  logic [XLEN-1:0] i_ex_pred_target,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush,
  output logic [31:0]     o_br_cnt,
  output logic [31:0]     o_mispred_cnt
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = XLEN - IDX_W - 2;
  localparam int CNT_W   = (RECOVER_CY > 1) ? $clog2(RECOVER_CY) : 1;

  logic [1:0]      r_ctr    [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [XLEN-1:0] r_target [ENTRIES];
  logic [ENTRIES-1:0] r_valid;

  state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic            r_redirect;
  logic [XLEN-1:0] r_redirect_pc;
  logic [31:0]     r_br_cnt, r_mispred_cnt;

  logic [IDX_W-1:0] w_f_idx, w_e_idx;
  logic [TAG_W-1:0] w_f_tag, w_e_tag;
  logic            w_hit, w_upd, w_train, w_mispred_raw, w_mispred;
  logic [1:0]      w_ctr_nxt;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_unused;

  // Fetch lookup reads the flops directly, so a same-cycle train is not visible yet.
  assign w_f_idx       = i_fetch_pc[IDX_W+1:2];
  assign w_f_tag       = i_fetch_pc[XLEN-1:IDX_W+2];
  assign w_hit         = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign o_pred_taken  = w_hit && r_ctr[w_f_idx][1];
  assign o_pred_target = o_pred_taken ? r_target[w_f_idx] : '0;
  assign w_unused      = ^i_fetch_pc[1:0];

  // EX contract: i_ex_valid qualifies all i_ex_* for one cycle; there is no ready,
  // the block accepts only in IDLE and silently drops EX inputs while in RECOVER.
  assign w_e_idx = i_ex_pc[IDX_W+1:2];
  assign w_e_tag = i_ex_pc[XLEN-1:IDX_W+2];
  assign w_upd   = i_ex_valid && (r_state == IDLE);
  assign w_train = w_upd && i_ex_is_branch;

  always_comb begin
    w_mispred_raw = i_ex_pred_taken;
    if (i_ex_is_branch)
      w_mispred_raw = (i_ex_taken != i_ex_pred_taken) ||
                      (i_ex_taken && i_ex_pred_taken && (i_ex_target != i_ex_pred_target));
  end
  assign w_mispred     = w_upd && w_mispred_raw;
  assign w_redirect_pc = (i_ex_is_branch && i_ex_taken) ? i_ex_target : i_ex_pc + XLEN'(4);

  bp_sat_ctr2 u_sat_ctr (
    .i_ctr   (r_ctr[w_e_idx]),
    .i_taken (i_ex_taken),
    .o_ctr   (w_ctr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i]    <= CTR_RESET;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (w_train) begin
      r_ctr[w_e_idx] <= w_ctr_nxt;
      if (i_ex_taken) begin
        r_valid[w_e_idx]  <= 1'b1;
        r_tag[w_e_idx]    <= w_e_tag;
        r_target[w_e_idx] <= i_ex_target;
      end
    end else if (w_mispred) begin
      // Only a non-branch can mispredict without training: drop its stale BTB entry.
      r_valid[w_e_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_mispred) begin
          w_state_nxt = RECOVER;
          w_cnt_nxt   = CNT_W'(RECOVER_CY - 1);
        end
      end
      RECOVER: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_redirect <= w_mispred;
      if (w_mispred) r_redirect_pc <= w_redirect_pc;
      if (w_train)   r_br_cnt      <= r_br_cnt + 32'd1;
      if (w_mispred) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign o_redirect    = r_redirect;
  assign o_flush       = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_br_cnt      = r_br_cnt;
  assign o_mispred_cnt = r_mispred_cnt;
endmodule
